// File: rtl/imm_encoder.sv
// Places an immediate into an instruction word (splitting oversized ADDI into LUI+ADDI).
// One-cycle latency; output words hold stable and input stalls while outReady is low.
module imm_encoder (
  input  logic        clk,
  input  logic        resetN,
  input  logic        inValid,
  output logic        inReady,
  input  logic [2:0]  immCntrl,
  input  logic [31:0] immVal,
  input  logic [31:0] baseInstr,
  output logic        outValid,
  input  logic        outReady,
  output logic [31:0] instrOut,
  output logic        rangeErr
);

  typedef enum logic [1:0] {EMPTY, ONE, LUI, ADDI} state_t;

  state_t      state_q;
  logic [31:0] instr_q;
  logic [31:0] addi_q;
  logic        err_q;

  logic [31:0] word_d;
  logic        err_d;
  logic        in_range;
  logic        fits12;
  logic        split_d;
  logic [19:0] lui_hi;
  logic [31:0] lui_word;
  logic [31:0] addi_word;
  logic        accept;

  assign fits12 = (&immVal[31:11]) | (~|immVal[31:11]);

  always_comb begin
    word_d   = baseInstr;
    in_range = 1'b1;
    case (immCntrl)
      3'b001: begin
        in_range       = ~|immVal[31:5];
        word_d[24:20]  = immVal[4:0];
      end
      3'b010: begin
        in_range       = fits12;
        word_d[31:20]  = immVal[11:0];
      end
      3'b011: begin
        in_range       = fits12;
        word_d[31:25]  = immVal[11:5];
        word_d[11:7]   = immVal[4:0];
      end
      3'b100: begin
        in_range       = ((&immVal[31:12]) | (~|immVal[31:12])) & ~immVal[0];
        word_d[31]     = immVal[12];
        word_d[30:25]  = immVal[10:5];
        word_d[11:8]   = immVal[4:1];
        word_d[7]      = immVal[11];
      end
      3'b101: begin
        in_range       = ~|immVal[11:0];
        word_d[31:12]  = immVal[31:12];
      end
      3'b110: begin
        in_range       = ((&immVal[31:20]) | (~|immVal[31:20])) & ~immVal[0];
        word_d[31]     = immVal[20];
        word_d[30:21]  = immVal[10:1];
        word_d[20]     = immVal[11];
        word_d[19:12]  = immVal[19:12];
      end
      default: in_range = 1'b0;
    endcase
    err_d = ~in_range;
  end

  // Only "addi rd, x0, imm" with rd != x0 can be rewritten as a LUI/ADDI pair.
  assign split_d = (immCntrl == 3'b010) && (baseInstr[6:0] == 7'b0010011) &&
                   (baseInstr[14:12] == 3'b000) && (baseInstr[19:15] == 5'd0) &&
                   (|baseInstr[11:7]) && !fits12;

  // Rounding the upper part compensates for ADDI sign-extending its low 12 bits.
  assign lui_hi    = immVal[31:12] + {19'd0, immVal[11]};
  assign lui_word  = {lui_hi, baseInstr[11:7], 7'b0110111};
  assign addi_word = {immVal[11:0], baseInstr[11:7], baseInstr[14:0]};

  assign inReady = resetN && ((state_q == EMPTY) ||
                              (((state_q == ONE) || (state_q == ADDI)) && outReady));
  assign accept  = inValid && inReady;

  always_ff @(posedge clk) begin
    if (!resetN) begin
      state_q <= EMPTY;
      instr_q <= 32'd0;
      addi_q  <= 32'd0;
      err_q   <= 1'b0;
    end else if (accept) begin
      state_q <= split_d ? LUI : ONE;
      instr_q <= split_d ? lui_word : word_d;
      err_q   <= split_d ? 1'b0 : err_d;
      addi_q  <= addi_word;
    end else if (outReady) begin
      case (state_q)
        LUI: begin
          state_q <= ADDI;
          instr_q <= addi_q;
          err_q   <= 1'b0;
        end
        ONE, ADDI: state_q <= EMPTY;
        default: state_q <= EMPTY;
      endcase
    end
  end

  assign outValid = (state_q != EMPTY);
  assign instrOut = instr_q;
  assign rangeErr = err_q;

endmodule

// File: tb/tb_imm_encoder.sv
// Directed and random stimulus against a queue-based reference of pending output words.
module tb_imm_encoder;

  logic        clk = 1'b0;
  logic        resetN = 1'b0;
  logic        inValid = 1'b0;
  logic        inReady;
  logic [2:0]  immCntrl = 3'd0;
  logic [31:0] immVal = 32'd0;
  logic [31:0] baseInstr = 32'd0;
  logic        outValid;
  logic        outReady = 1'b0;
  logic [31:0] instrOut;
  logic        rangeErr;

  imm_encoder dut (
    .clk(clk), .resetN(resetN), .inValid(inValid), .inReady(inReady),
    .immCntrl(immCntrl), .immVal(immVal), .baseInstr(baseInstr),
    .outValid(outValid), .outReady(outReady), .instrOut(instrOut), .rangeErr(rangeErr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] w;
    logic        e;
    logic        rt;
    logic [2:0]  c;
    logic [31:0] imm;
  } exp_t;

  exp_t        q[$];
  int          tests = 0;
  int          fails = 0;
  logic        obs_v, obs_e, obs_r;
  logic [31:0] obs_w;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Immediate extender: recovers the immediate value from an encoded word.
  function automatic logic [31:0] extend(input logic [2:0] c, input logic [31:0] w);
    int sw;
    int r;
    sw = w;
    r  = 0;
    case (c)
      3'd1: r = (sw >> 20) & 31;
      3'd2: r = sw >>> 20;
      3'd3: r = (sw >>> 25) * 32 + ((sw >> 7) & 31);
      3'd4: r = (w[31] ? -4096 : 0) + ((sw >> 7) & 1) * 2048 +
                ((sw >> 25) & 63) * 32 + ((sw >> 8) & 15) * 2;
      3'd5: r = sw & 32'hFFFFF000;
      3'd6: r = (w[31] ? -1048576 : 0) + ((sw >> 12) & 255) * 4096 +
                ((sw >> 20) & 1) * 2048 + ((sw >> 21) & 1023) * 2;
      default: r = 0;
    endcase
    return r;
  endfunction

  task automatic push_model(input logic [2:0] c, input logic [31:0] imm, input logic [31:0] base);
    exp_t        e;
    int          v;
    logic        ok;
    logic [31:0] w;
    logic [31:0] rd;
    v  = imm;
    rd = (base >> 7) & 31;
    ok = 1'b0;
    w  = base;
    case (c)
      3'd1: begin ok = (imm <= 31); w = (base & ~32'h01F00000) | ((imm & 31) << 20); end
      3'd2: begin ok = (v >= -2048 && v <= 2047); w = (base & 32'h000FFFFF) | (imm << 20); end
      3'd3: begin
        ok = (v >= -2048 && v <= 2047);
        w = (base & 32'h01FFF07F) | (((imm >> 5) & 127) << 25) | ((imm & 31) << 7);
      end
      3'd4: begin
        ok = (v >= -4096 && v <= 4095 && (imm % 2) == 0);
        w = (base & 32'h01FFF07F) | (((imm >> 12) & 1) << 31) | (((imm >> 5) & 63) << 25) |
            (((imm >> 1) & 15) << 8) | (((imm >> 11) & 1) << 7);
      end
      3'd5: begin ok = ((imm % 4096) == 0); w = (base & 32'hFFF) | (imm & 32'hFFFFF000); end
      3'd6: begin
        ok = (v >= -1048576 && v <= 1048575 && (imm % 2) == 0);
        w = (base & 32'hFFF) | (((imm >> 20) & 1) << 31) | (((imm >> 1) & 1023) << 21) |
            (((imm >> 11) & 1) << 20) | (((imm >> 12) & 255) << 12);
      end
      default: begin ok = 1'b0; w = base; end
    endcase
    if (c == 3'd2 && (base % 128) == 19 && ((base >> 12) & 7) == 0 &&
        ((base >> 15) & 31) == 0 && rd != 0 && !ok) begin
      e = '{w: ((imm + 32'h800) & 32'hFFFFF000) | (rd << 7) | 32'h37, e: 1'b0, rt: 1'b0, c: c, imm: imm};
      q.push_back(e);
      e = '{w: (base & 32'h000FFFFF) | ((imm & 32'hFFF) << 20) | (rd << 15), e: 1'b0, rt: 1'b0, c: c, imm: imm};
      q.push_back(e);
    end else begin
      e = '{w: w, e: !ok, rt: ok, c: c, imm: imm};
      q.push_back(e);
    end
  endtask

  // One clock cycle: drive, sample at the falling edge, update the model.
  task automatic step(input logic iv, input logic [2:0] c, input logic [31:0] imm,
                      input logic [31:0] base, input logic ordy, input logic rn);
    logic exp_r;
    inValid = iv; immCntrl = c; immVal = imm; baseInstr = base; outReady = ordy; resetN = rn;
    @(negedge clk);
    obs_v = outValid; obs_w = instrOut; obs_e = rangeErr; obs_r = inReady;
    exp_r = rn && (q.size() == 0 || (q.size() == 1 && ordy));
    chk("outValid", {31'd0, outValid}, {31'd0, q.size() != 0});
    chk("inReady", {31'd0, inReady}, {31'd0, exp_r});
    if (q.size() != 0) begin
      chk("instrOut", instrOut, q[0].w);
      chk("rangeErr", {31'd0, rangeErr}, {31'd0, q[0].e});
      if (q[0].rt && ordy && rn) chk("roundtrip", extend(q[0].c, instrOut), q[0].imm);
    end
    if (!rn) q.delete();
    else begin
      if (q.size() != 0 && ordy) void'(q.pop_front());
      if (iv && exp_r) push_model(c, imm, base);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] r, imm, base;
    logic [2:0]  c;
    int          sel;

    @(posedge clk); #1;
    step(1'b1, 3'd2, 32'd5, 32'h13, 1'b1, 1'b0);
    chk("rst_valid", {31'd0, obs_v}, 32'd0);
    chk("rst_instr", obs_w, 32'd0);
    chk("rst_err", {31'd0, obs_e}, 32'd0);
    chk("rst_inready", {31'd0, obs_r}, 32'd0);

    step(1'b1, 3'd2, 32'hFFFFFFFF, 32'h00000013, 1'b1, 1'b1);
    step(1'b1, 3'd4, 32'h00000800, 32'h00000063, 1'b1, 1'b1);
    chk("i_word", obs_w, 32'hFFF00013);
    chk("i_err", {31'd0, obs_e}, 32'd0);
    step(1'b1, 3'd6, 32'h00000003, 32'h0000006F, 1'b1, 1'b1);
    chk("b_word", obs_w, 32'h000000E3);
    chk("b_err", {31'd0, obs_e}, 32'd0);
    step(1'b1, 3'd3, 32'h00000800, 32'h00000023, 1'b1, 1'b1);
    chk("j_err", {31'd0, obs_e}, 32'd1);
    step(1'b1, 3'd1, 32'd32, 32'h00001013, 1'b1, 1'b1);
    chk("s_err", {31'd0, obs_e}, 32'd1);
    chk("s_hi7", obs_w >> 25, 32'h40);
    step(1'b1, 3'd7, 32'h0000ABCD, 32'h12345678, 1'b1, 1'b1);
    chk("sh_err", {31'd0, obs_e}, 32'd1);
    chk("sh_field", (obs_w >> 20) & 31, 32'd0);
    step(1'b1, 3'd2, 32'h12345FFF, 32'h00000513, 1'b1, 1'b1);
    chk("inv_word", obs_w, 32'h12345678);
    chk("inv_err", {31'd0, obs_e}, 32'd1);
    step(1'b0, 3'd0, 32'd0, 32'd0, 1'b1, 1'b1);
    chk("lui_word", obs_w, 32'h12346537);
    chk("lui_inready", {31'd0, obs_r}, 32'd0);
    step(1'b0, 3'd0, 32'd0, 32'd0, 1'b1, 1'b1);
    chk("addi_word", obs_w, 32'hFFF50513);
    chk("addi_err", {31'd0, obs_e}, 32'd0);

    // Backpressure: held word must not change and nothing new enters.
    step(1'b1, 3'd2, 32'h00000123, 32'h00000093, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 3'd3, 32'h00000010, 32'h00000023, 1'b0, 1'b1);
      chk("bp_word", obs_w, 32'h12300093);
      chk("bp_inready", {31'd0, obs_r}, 32'd0);
    end
    step(1'b0, 3'd0, 32'd0, 32'd0, 1'b1, 1'b1);
    step(1'b0, 3'd0, 32'd0, 32'd0, 1'b1, 1'b1);

    // Reset while the LUI half of a pair is held.
    step(1'b1, 3'd2, 32'h12345FFF, 32'h00000513, 1'b1, 1'b1);
    step(1'b0, 3'd0, 32'd0, 32'd0, 1'b1, 1'b0);
    chk("mid_lui", obs_w, 32'h12346537);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 3'd0, 32'd0, 32'd0, 1'b1, 1'b1);
      chk("mid_novalid", {31'd0, obs_v}, 32'd0);
    end

    for (int n = 0; n < 400; n++) begin
      c   = 3'($urandom_range(0, 7));
      sel = $urandom_range(0, 4);
      r   = $urandom;
      case (sel)
        0: imm = r;
        1: imm = $urandom_range(0, 63);
        2: imm = 32'($urandom_range(0, 8191)) - 32'd4096;
        3: imm = (32'($urandom_range(0, 4194303)) - 32'd2097152) & ~32'd1;
        default: imm = r & 32'hFFFFF000;
      endcase
      r = $urandom;
      if ($urandom_range(0, 2) == 0) base = (r & 32'hFFF00F80) | 32'h13;
      else base = r;
      step($urandom_range(0, 3) != 0, c, imm, base, $urandom_range(0, 9) < 7, 1'b1);
    end
    for (int i = 0; i < 4; i++) step(1'b0, 3'd0, 32'd0, 32'd0, 1'b1, 1'b1);
    chk("drained", q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/imm_encoder.md
IMM_ENCODER -- requirements
Module: imm_encoder

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset. Port clk (in, 1): rising-edge clock. Port resetN (in, 1): synchronous active-low reset.
REQ-002 inValid  in  1  request word valid.
REQ-003 inReady  out  1  block accepts the request this cycle.
REQ-004 immCntrl  in  3  immediate type: 001 SHAMT, 010 I, 011 S, 100 B, 101 U, 110 J; 000/111 invalid.
REQ-005 immVal  in  32  immediate in extended form, as the immediate extender would reproduce it (U: value already shifted, imm[11:0]=0).
REQ-006 baseInstr  in  32  instruction with opcode/rd/rs/funct fields; immediate bits are don't-care.
REQ-007 outValid  out  1  instrOut valid.
REQ-008 outReady  in  1  consumer takes instrOut this cycle.
REQ-009 instrOut  out  32  assembled instruction word.
REQ-010 rangeErr  out  1  immVal not representable; qualified by outValid.

Function
REQ-011 Field placement: SHAMT [24:20]=imm[4:0]; I [31:20]=imm[11:0]; S [31:25]=imm[11:5], [11:7]=imm[4:0]; B [31]=imm[12], [30:25]=imm[10:5], [11:8]=imm[4:1], [7]=imm[11]; U [31:12]=imm[31:12]; J [31]=imm[20], [30:21]=imm[10:1], [20]=imm[11], [19:12]=imm[19:12]. All other bits SHALL come from baseInstr.
REQ-012 Range rules: SHAMT 0..31; I and S signed 12-bit; B signed 13-bit with imm[0]=0; J signed 21-bit with imm[0]=0; U imm[11:0]=0. On violation, rangeErr=1 and the fields SHALL be filled from the truncated immVal bits.
REQ-013 Invalid immCntrl: instrOut=baseInstr, rangeErr=1.
REQ-014 Split case: immCntrl=I with baseInstr[6:0]=0010011, [14:12]=000, [19:15]=0, [11:7]≠0, and immVal outside signed 12-bit.
 - The block SHALL emit two words, rangeErr=0 on both.
 - Word 1: LUI = {hi20, rd, 0110111}, where hi20=(immVal+32'h800)[31:12].
 - Word 2: ADDI = baseInstr with [31:20]=immVal[11:0] and [19:15]=rd.
REQ-015 State machine with states EMPTY, ONE (single word held), LUI (first split word held), ADDI (second split word held).
REQ-016 inReady SHALL be 1 when the state is EMPTY, or when the state is ONE or ADDI and outReady=1; otherwise 0. It SHALL be 0 while resetN=0.
REQ-017 Accept = inValid && inReady. On accept the next state SHALL be LUI for a split request and ONE otherwise.
REQ-018 From LUI with outReady=1, the next state SHALL be ADDI. From ONE or ADDI with outReady=1 and no accept, the next state SHALL be EMPTY.
REQ-019 Latency: outValid SHALL rise one cycle after accept.
REQ-020 Throughput: one word per cycle for non-split requests under continuous outReady; a split request SHALL occupy two output cycles.
REQ-021 While outValid=1 and outReady=0, instrOut and rangeErr SHALL hold stable and no request SHALL be accepted.
REQ-022 outValid SHALL be 1 exactly when the state is not EMPTY.
REQ-023 Round-trip: when rangeErr=0 for a non-split word, the immediate extender applied to (immCntrl, instrOut[31:7]) SHALL return immVal.

Reset
REQ-024 While resetN=0 at a clk edge, the state SHALL become EMPTY, and outValid, instrOut and rangeErr SHALL become 0.
REQ-025 Reset during LUI or ADDI SHALL discard the pending pair; no second word SHALL be emitted after reset release.

Verification
REQ-026 I-type: immVal=FFFFFFFF, base=00000013, outReady=1 -> next cycle outValid=1, instrOut=FFF00013, rangeErr=0.
REQ-027 B-type: immVal=00000800, base=00000063 -> instrOut=000000E3, rangeErr=0; J-type immVal=00000003 -> rangeErr=1.
REQ-028 Split: base=00000513, immVal=12345FFF -> LUI word 12346537, then ADDI word FFF50513; inReady=0 while the LUI word is held.
REQ-029 Backpressure: outReady=0 for 3 cycles with inValid=1 -> instrOut stable, inReady=0, no word lost or duplicated; random stream plus round-trip check through the immediate extender.
REQ-030 Errors: S-type immVal=00000800 -> rangeErr=1, instrOut[31:25]=7'h40; SHAMT immVal=32 -> rangeErr=1, [24:20]=0; immCntrl=111 -> instrOut=baseInstr, rangeErr=1.
REQ-031 Reset mid-pair: resetN=0 while the LUI word is held -> next cycle outValid=0, and the ADDI word never appears.
